// File: rtl/mac_accumulator_block_pkg.sv
// Shared encodings for the MAC accumulation stage: lane mode codes,
// the bypass bit position, FSM states and the per-mode carry gating.
package mac_accumulator_block_pkg;

  localparam logic [1:0] MAC_SINGLE     = 2'b00;
  localparam logic [1:0] MAC_DUAL       = 2'b01;
  localparam logic [1:0] MAC_QUAD       = 2'b10;
  localparam int unsigned MAC_BYPASS_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } mac_acc_state_t;

  // Carry enables for the lane boundaries {2->3, 1->2, 0->1}.
  // Dual pairs lanes 0/1 and 2/3; quad chains all four; 11 acts as single.
  function automatic logic [2:0] mac_carry_en(input logic [1:0] mode);
    logic [2:0] en;
    en = '0;
    case (mode)
      MAC_DUAL: en = 3'b101;
      MAC_QUAD: en = 3'b111;
      default:  en = 3'b000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/n_bit_adder.sv
// N-bit ripple-style adder lane with carry in/out; four of these form the
// accumulator carry chain.
module n_bit_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Full-width add; carry-out is the extra top bit.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  end

endmodule

// File: rtl/mac_accumulator_block.sv
// Accumulation stage behind the MAC combiner: sums a programmable window of
// four-lane samples, with the lane carry chain gated by single/dual/quad mode,
// and presents the window result on a valid/ready output.
module mac_accumulator_block
  import mac_accumulator_block_pkg::*;
#(
  parameter int MAC_CONF_WIDTH = 3,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH,
  parameter int MAC_CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic [MAC_CNT_WIDTH-1:0]  len,
  input  logic                      start,
  input  logic [MAC_ACC_WIDTH-1:0]  init0,
  input  logic [MAC_ACC_WIDTH-1:0]  init1,
  input  logic [MAC_ACC_WIDTH-1:0]  init2,
  input  logic [MAC_ACC_WIDTH-1:0]  init3,
  input  logic                      in_valid,
  input  logic [MAC_ACC_WIDTH-1:0]  in0,
  input  logic [MAC_ACC_WIDTH-1:0]  in1,
  input  logic [MAC_ACC_WIDTH-1:0]  in2,
  input  logic [MAC_ACC_WIDTH-1:0]  in3,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAC_ACC_WIDTH-1:0]  acc0,
  output logic [MAC_ACC_WIDTH-1:0]  acc1,
  output logic [MAC_ACC_WIDTH-1:0]  acc2,
  output logic [MAC_ACC_WIDTH-1:0]  acc3,
  output logic                      busy
);

  mac_acc_state_t state_q, state_d;

  logic [MAC_ACC_WIDTH-1:0] acc_q0, acc_q1, acc_q2, acc_q3;
  logic [MAC_ACC_WIDTH-1:0] sum0, sum1, sum2, sum3;
  logic [MAC_CNT_WIDTH-1:0] cnt_q;
  logic [MAC_CNT_WIDTH-1:0] last_q;
  logic [MAC_CNT_WIDTH-1:0] last_d;
  logic [1:0]               mode_q;
  logic [2:0]               carry_en;
  logic                     cout0, cout1, cout2;
  logic                     unused_cout3;
  logic                     accept;
  logic                     last_sample;
  logic                     load;

  assign carry_en = mac_carry_en(mode_q);

  n_bit_adder #(.N(MAC_ACC_WIDTH)) u_lane0 (
    .a(acc_q0), .b(in0), .cin(1'b0),                 .sum(sum0), .cout(cout0)
  );
  n_bit_adder #(.N(MAC_ACC_WIDTH)) u_lane1 (
    .a(acc_q1), .b(in1), .cin(cout0 & carry_en[0]),  .sum(sum1), .cout(cout1)
  );
  n_bit_adder #(.N(MAC_ACC_WIDTH)) u_lane2 (
    .a(acc_q2), .b(in2), .cin(cout1 & carry_en[1]),  .sum(sum2), .cout(cout2)
  );
  n_bit_adder #(.N(MAC_ACC_WIDTH)) u_lane3 (
    .a(acc_q3), .b(in3), .cin(cout2 & carry_en[2]),  .sum(sum3), .cout(unused_cout3)
  );

  // Handshake and window-control decode; en gates every transfer.
  always_comb begin
    accept      = in_ready & in_valid;
    last_sample = accept & (cnt_q == last_q);
    load        = en & start &
                  ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    // Index of the final sample: bypass and len=0 both collapse to one sample.
    if (cfg[MAC_BYPASS_BIT] || (len == '0)) begin
      last_d = '0;
    end else begin
      last_d = len - 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_ACCUM;
        ST_ACCUM: if (last_sample) state_d = ST_DONE;
        ST_DONE:  if (out_ready) state_d = start ? ST_ACCUM : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from state.
  always_comb begin
    in_ready  = en && (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // Accumulator, window counter, latched config and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q0 <= '0;
      acc_q1 <= '0;
      acc_q2 <= '0;
      acc_q3 <= '0;
      acc0   <= '0;
      acc1   <= '0;
      acc2   <= '0;
      acc3   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      mode_q <= MAC_SINGLE;
    end else if (load) begin
      acc_q0 <= init0;
      acc_q1 <= init1;
      acc_q2 <= init2;
      acc_q3 <= init3;
      cnt_q  <= '0;
      last_q <= last_d;
      mode_q <= cfg[1:0];
    end else if (accept) begin
      acc_q0 <= sum0;
      acc_q1 <= sum1;
      acc_q2 <= sum2;
      acc_q3 <= sum3;
      cnt_q  <= cnt_q + 1'b1;
      if (last_sample) begin
        acc0 <= sum0;
        acc1 <= sum1;
        acc2 <= sum2;
        acc3 <= sum3;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator_block.sv
// Directed bench for mac_accumulator_block: hand-computed windows across
// single/dual/quad modes, back-pressure, enable gating, reset and len edges.
module tb_mac_accumulator_block;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b1;
  logic [2:0]   cfg = '0;
  logic [7:0]   len = '0;
  logic         start = 1'b0;
  logic [W-1:0] init0 = '0, init1 = '0, init2 = '0, init3 = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] acc0, acc1, acc2, acc3;
  logic         busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mac_accumulator_block #(
    .MAC_CONF_WIDTH(3),
    .MAC_MIN_WIDTH(8),
    .MAC_ACC_WIDTH(W),
    .MAC_CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg(cfg), .len(len), .start(start),
    .init0(init0), .init1(init1), .init2(init2), .init3(init3),
    .in_valid(in_valid), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .acc0(acc0), .acc1(acc1), .acc2(acc2), .acc3(acc3), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                         input logic [W-1:0] e2, input logic [W-1:0] e3);
    chk({tag, ".acc0"}, acc0, e0);
    chk({tag, ".acc1"}, acc1, e1);
    chk({tag, ".acc2"}, acc2, e2);
    chk({tag, ".acc3"}, acc3, e3);
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_win(input logic [2:0] c, input logic [7:0] l,
                          input logic [W-1:0] i0, input logic [W-1:0] i1,
                          input logic [W-1:0] i2, input logic [W-1:0] i3);
    cfg = c; len = l; init0 = i0; init1 = i1; init2 = i2; init3 = i3;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] s0, input logic [W-1:0] s1,
                      input logic [W-1:0] s2, input logic [W-1:0] s3);
    in0 = s0; in1 = s1; in2 = s2; in3 = s3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic close_win();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst.out_valid", {31'b0, out_valid}, 0);
    chk("rst.in_ready", {31'b0, in_ready}, 0);
    chk("rst.busy", {31'b0, busy}, 0);
    chk_acc("rst", 0, 0, 0, 0);
    rst = 1'b1;
    tick();

    // Single, len=3: lane0 wraps, carry into lane1 dropped
    open_win(3'b000, 8'd3, 0, 0, 0, 0);
    chk("t1.in_ready", {31'b0, in_ready}, 1);
    chk("t1.busy", {31'b0, busy}, 1);
    send(32'hFFFF_FFFF, 1, 0, 0);
    send(32'hFFFF_FFFF, 1, 0, 0);
    chk("t1.not_done", {31'b0, out_valid}, 0);
    send(32'hFFFF_FFFF, 1, 0, 0);
    chk("t1.out_valid", {31'b0, out_valid}, 1);
    chk("t1.in_ready_done", {31'b0, in_ready}, 0);
    chk_acc("t1", 32'hFFFF_FFFD, 3, 0, 0);
    close_win();
    chk("t1.idle", {31'b0, busy}, 0);
    chk_acc("t1.hold", 32'hFFFF_FFFD, 3, 0, 0);

    // Dual, len=1: lane0->1 carry passes
    open_win(3'b001, 8'd1, 32'hFFFF_FFFF, 0, 0, 0);
    send(1, 0, 0, 0);
    chk("t2a.out_valid", {31'b0, out_valid}, 1);
    chk_acc("t2a", 0, 1, 0, 0);
    close_win();

    // Dual, len=1: lane1->2 carry blocked
    open_win(3'b001, 8'd1, 0, 32'hFFFF_FFFF, 0, 0);
    send(0, 1, 0, 0);
    chk_acc("t2b", 0, 0, 0, 0);
    close_win();

    // Quad, len=2: carry ripples from lane1 into lane2
    open_win(3'b010, 8'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    cfg = 3'b000; len = 8'd9; // mid-window changes must not matter
    send(1, 0, 0, 0);
    send(1, 0, 0, 0);
    chk("t3.out_valid", {31'b0, out_valid}, 1);
    chk_acc("t3", 1, 0, 1, 0);
    close_win();

    // Back-pressure: DONE holds while out_ready=0
    open_win(3'b000, 8'd1, 5, 0, 0, 0);
    send(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.out_valid", {31'b0, out_valid}, 1);
      chk("bp.in_ready", {31'b0, in_ready}, 0);
      chk("bp.acc0", acc0, 6);
    end
    // en=0 blocks the output handshake
    en = 1'b0; out_ready = 1'b1;
    tick();
    chk("en0.out_valid", {31'b0, out_valid}, 1);
    en = 1'b1; out_ready = 1'b0;
    // out_ready together with start: straight back into ACCUM
    out_ready = 1'b1;
    open_win(3'b000, 8'd1, 10, 0, 0, 0);
    out_ready = 1'b0;
    chk("bp.restart_in_ready", {31'b0, in_ready}, 1);
    chk("bp.restart_out_valid", {31'b0, out_valid}, 0);
    chk("bp.restart_acc0", acc0, 6);
    send(1, 0, 0, 0);
    chk("bp.new_acc0", acc0, 11);
    close_win();

    // Reset mid-window discards the partial sum
    open_win(3'b000, 8'd4, 1, 1, 1, 1);
    send(1, 1, 1, 1);
    send(1, 1, 1, 1);
    rst = 1'b0;
    #1;
    chk("mrst.busy", {31'b0, busy}, 0);
    chk("mrst.in_ready", {31'b0, in_ready}, 0);
    chk("mrst.out_valid", {31'b0, out_valid}, 0);
    chk_acc("mrst", 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    open_win(3'b000, 8'd1, 0, 0, 0, 0);
    send(7, 0, 0, 0);
    chk("mrst.restart_valid", {31'b0, out_valid}, 1);
    chk_acc("mrst.restart", 7, 0, 0, 0);
    close_win();

    // len=0 acts as one sample; en=0 stalls the input handshake first
    open_win(3'b000, 8'd0, 3, 0, 0, 0);
    en = 1'b0;
    in_valid = 1'b1; in0 = 5;
    #1;
    chk("len0.en0_in_ready", {31'b0, in_ready}, 0);
    tick();
    in_valid = 1'b0;
    en = 1'b1;
    send(5, 0, 0, 0);
    chk("len0.out_valid", {31'b0, out_valid}, 1);
    chk_acc("len0", 8, 0, 0, 0);
    close_win();

    // Bypass with len=7 still closes after one sample
    open_win(3'b100, 8'd7, 2, 0, 0, 0);
    send(7, 0, 0, 0);
    chk("byp.out_valid", {31'b0, out_valid}, 1);
    chk_acc("byp", 9, 0, 0, 0);
    close_win();
    chk("byp.idle", {31'b0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
